keyproc_gen: RTL
================

Name: keyproc_gen

Overview:
- Parametrised key-to-instruction translator for the GPU function pads; next generation of the 4-key function-2 key processor.
- Adds:
  - N keys
  - input synchronisation and debounce
  - press-edge event generation
  - auto-repeat while a key is held
  - valid/ready handshake toward the GPU instruction consumer, with overflow reporting
- Sits between raw board key inputs and the GPU instruction write port.

Parameters:
- NUM_KEYS, 4: number of key inputs (1..15).
- INSTR_W, 3: instruction width; must satisfy 2**INSTR_W > NUM_KEYS.
- DEBOUNCE_CYCLES, 16: consecutive stable cycles required before a debounced level flips (>=1).
- REPEAT_DELAY, 0: cycles of hold before the first repeat event; 0 disables auto-repeat.
- REPEAT_PERIOD, 1: cycles between subsequent repeat events (>=1).

Ports:
- sysclk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- keys  in  NUM_KEYS  raw asynchronous key levels, 1 = pressed
- ready  in  1  consumer accepts instruction this cycle
- write  out  1  instruction valid; held until accepted
- instruction  out  INSTR_W  instruction code; 0 whenever write=0
- overflow  out  1  one-cycle pulse: an event was dropped

Behaviour:
- Reset: one clock and one synchronous, active-high reset; reset sampled on sysclk rising edge. While reset=1 at an edge, all of the following clear:
  - synchronisers, debounced levels, debounce counters, repeat counter
  - active key, FSM (to IDLE)
  - write=0, instruction=0, overflow=0
- Reset mid-operation discards any pending instruction.
- Keys held through reset are treated as new presses once reset deasserts.
- Synchronisation: each key passes through a 2-flop synchroniser.
- Debounce (per key):
  - The counter resets whenever the synchronised level equals the debounced level.
  - Otherwise it increments; when it reaches DEBOUNCE_CYCLES the debounced level flips and the counter clears.
- Event timing:
  - A press event is a debounced 0->1 transition.
  - If the raw key changes and stays stable, write rises exactly DEBOUNCE_CYCLES+3 edges after the first edge that samples the new level.
- Code mapping: key index i produces code NUM_KEYS-i, zero-extended to INSTR_W.
  - NUM_KEYS=4 gives key3=1, key2=2, key1=3, key0=4.
  - Code 0 is never issued.
- Priority: if several press events occur in the same cycle, only the highest index produces an event. Lower-index presses that cycle are discarded, not queued and not counted as overflow.
- Repeat FSM (states IDLE, DELAY, REPEAT):
  - IDLE: on a press event, active key := winning index; go to DELAY with the counter cleared (stay IDLE if REPEAT_DELAY=0; active key still recorded).
  - DELAY: count while the active key's debounced level =1. At REPEAT_DELAY counts, emit a repeat event (same code), clear the counter, go to REPEAT.
  - REPEAT: emit a repeat event every REPEAT_PERIOD counts.
  - Release: in DELAY or REPEAT, the active key's debounced level going 0 returns the FSM to IDLE with no event.
  - New press of any key in DELAY or REPEAT: emit that key's event, update the active key, restart DELAY with the counter cleared. A press event wins over a repeat event in the same cycle; the repeat is discarded.
  - Releasing a non-active key has no effect.
- Output handshake (one-entry holding register):
  - Transfer occurs on an edge with write=1 and ready=1.
  - Event with write=0: next cycle write=1 and instruction=code.
  - Event with write=1 and ready=1: new code loaded; write stays 1.
  - Event with write=1 and ready=0: event dropped, pending instruction unchanged, overflow=1 next cycle for exactly one cycle.
  - No event with write=1 and ready=1: next cycle write=0, instruction=0.
  - instruction is stable while write=1 and ready=0.
- ready is ignored while write=0.

Test Plan:
(All with NUM_KEYS=4, INSTR_W=3, DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8, ready=1 unless stated.)
- Debounce latency: raise keys[2] stable -> write=1 with instruction=2 exactly 7 edges later, for one cycle, then 0/0.
- Bounce rejection: keys[0] toggles with high pulses of 3 cycles for 40 cycles, then stays 0 -> write never asserts.
- Simultaneous press: keys 4'b1011 in the same cycle -> single event, instruction=1. Later release of keys[3] with keys[1] held -> no new event.
- Auto-repeat: hold keys[1] -> code 3 at the press, again 20 cycles after the press event, then every 8 cycles. Release -> no further events after the debounced fall.
- Backpressure: ready=0, press keys[0] then keys[3] -> write=1 and instruction=4 held stable, overflow pulses once. ready=1 -> transfer, then write=0.
- Reset mid-operation: reset=1 for one edge while write=1 with repeat active -> next cycle write=0, instruction=0, FSM IDLE. A key held through reset yields a fresh code after 7 edges.

Source files
------------

// File: rtl/keyproc_gen.sv
// Key-to-instruction translator: sync, debounce, press edge, auto-repeat, 1-entry output register.
// write rises DEBOUNCE_CYCLES+3 edges after a key change; events arriving while a stalled word is held are dropped and flagged.
module keyproc_gen #(
  parameter int NUM_KEYS        = 4,
  parameter int INSTR_W         = 3,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 0,
  parameter int REPEAT_PERIOD   = 1
) (
  input  logic                sysclk,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] keys,
  input  logic                ready,
  output logic                write,
  output logic [INSTR_W-1:0]  instruction,
  output logic                overflow
);

  localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RMAX  = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int CNT_W = $clog2(RMAX + 1);
  localparam int KW    = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;

  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;

  logic [NUM_KEYS-1:0] sync1, sync2, deb, deb_d, press;
  logic [DB_W-1:0]     db_cnt [NUM_KEYS];

  state_t              state, state_nx;
  logic [CNT_W-1:0]    cnt, cnt_nx;
  logic [KW-1:0]       act, act_nx, win;
  logic                any_press;
  logic                ev_nx, evt_vld;
  logic [INSTR_W-1:0]  ev_code_nx, evt_code;

  function automatic logic [INSTR_W-1:0] code_of(input logic [KW-1:0] idx);
    return INSTR_W'(NUM_KEYS - int'(idx));
  endfunction

  always_ff @(posedge sysclk) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      deb_d <= '0;
      for (int i = 0; i < NUM_KEYS; i++) db_cnt[i] <= '0;
    end else begin
      sync1 <= keys;
      sync2 <= sync1;
      deb_d <= deb;
      for (int i = 0; i < NUM_KEYS; i++) begin
        if (sync2[i] == deb[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          deb[i]    <= ~deb[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  assign press = deb & ~deb_d;

  // Later indices overwrite earlier ones, so the highest pressed index wins.
  always_comb begin
    any_press = 1'b0;
    win       = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (press[i]) begin
        any_press = 1'b1;
        win       = KW'(i);
      end
    end
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      act   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      act   <= act_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    act_nx     = act;
    ev_nx      = 1'b0;
    ev_code_nx = '0;
    if (any_press) begin
      act_nx     = win;
      ev_nx      = 1'b1;
      ev_code_nx = code_of(win);
      cnt_nx     = '0;
      state_nx   = (REPEAT_DELAY == 0) ? IDLE : DELAY;
    end else if (state != IDLE) begin
      if (!deb[act]) begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end else if (cnt == ((state == DELAY) ? DLY_LAST : PER_LAST)) begin
        ev_nx      = 1'b1;
        ev_code_nx = code_of(act);
        cnt_nx     = '0;
        state_nx   = REPEAT;
      end else begin
        cnt_nx = cnt + CNT_W'(1);
      end
    end
  end

  // Event stage is registered, then offered to the one-entry output holding register.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      evt_vld     <= 1'b0;
      evt_code    <= '0;
      write       <= 1'b0;
      instruction <= '0;
      overflow    <= 1'b0;
    end else begin
      evt_vld  <= ev_nx;
      evt_code <= ev_code_nx;
      overflow <= 1'b0;
      if (evt_vld) begin
        if (!write || ready) begin
          write       <= 1'b1;
          instruction <= evt_code;
        end else begin
          overflow <= 1'b1;
        end
      end else if (write && ready) begin
        write       <= 1'b0;
        instruction <= '0;
      end
    end
  end

endmodule
